// File: rtl/smem_rd_arb_pkg.sv
// Shared field layout of the CCI-P read mdata word used by the SMEM read arbiter.
package smem_rd_arb_pkg;

   localparam int MDATA_ID_LSB = 8;
   localparam int MDATA_ID_W   = 4;
   localparam int MDATA_TAG_W  = 8;

   typedef struct packed {
      logic [3:0] rsvd;
      logic [3:0] id;
      logic [7:0] tag;
   } t_rd_mdata;

endpackage

// File: rtl/smem_rd_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: lowest index at or above ptr wins, wrapping around.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_id,
   output logic          any
);

   logic [2*N-1:0] req2;
   logic [2*N-1:0] mask2;
   logic [2*N-1:0] masked;
   logic           found;

   // Duplicate the request vector, drop the bits below ptr, then take the first set bit.
   // The upper copy keeps every bit, so a request below ptr is found on the wrap.
   always_comb begin
      req2   = {req, req};
      mask2  = {(2*N){1'b1}} << ptr;
      masked = req2 & mask2;
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      any    = |req;
      for (int j = 0; j < 2*N; j++) begin
         if (masked[j] && !found) begin
            found          = 1'b1;
            gnt_id         = IW'(j % N);
            gnt[j % N]     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/smem_rd_arbiter.sv
// Shares the c0 Tx read channel among NUM_REQ SMEM requesters with per-requester credits,
// and routes c0 Rx responses back to the requester whose ID rides in mdata[11:8].
module smem_rd_arbiter
   import smem_rd_arb_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int ADDR_W          = 42,
   parameter int MAX_OUTSTANDING = 32
) (
   input  logic                    CLK_400M,
   input  logic                    spl_reset_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*8-1:0]    req_tag,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic                    spl_tx_rd_almostfull,
   output logic                    afu_tx_rd_valid,
   output logic [ADDR_W-1:0]       afu_tx_rd_addr,
   output logic [15:0]             afu_tx_rd_mdata,
   input  logic                    spl_rx_rd_valid,
   input  logic [15:0]             spl_rx_rd_mdata,
   input  logic [511:0]            spl_rx_data,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic [7:0]              rsp_tag,
   output logic [511:0]            rsp_data,
   output logic                    idle,
   output logic                    err
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   logic [IW-1:0]         ptr_q, ptr_d;
   logic                  tx_valid_q, tx_valid_d;
   logic [ADDR_W-1:0]     tx_addr_q, tx_addr_d;
   t_rd_mdata             tx_mdata_q, tx_mdata_d;
   logic [CW-1:0]         cnt_q [NUM_REQ];
   logic [CW-1:0]         cnt_d [NUM_REQ];
   logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [7:0]            rsp_tag_q, rsp_tag_d;
   logic [511:0]          rsp_data_q, rsp_data_d;
   logic                  err_q, err_d;

   logic [NUM_REQ-1:0]    elig;
   logic [NUM_REQ-1:0]    gnt;
   logic [IW-1:0]         gnt_id;
   logic                  gnt_any;
   logic [NUM_REQ-1:0]    hit;
   logic                  drop;
   logic [MDATA_ID_W-1:0] rx_id;
   logic [MDATA_TAG_W-1:0] rx_tag;
   logic                  unused_rx_rsvd;

   assign rx_id          = spl_rx_rd_mdata[MDATA_ID_LSB +: MDATA_ID_W];
   assign rx_tag         = spl_rx_rd_mdata[MDATA_TAG_W-1:0];
   assign unused_rx_rsvd = ^spl_rx_rd_mdata[15:12];

   // Eligibility: pending request with credit left, channel not almost full, not in reset.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         elig[i] = req_valid[i] & (cnt_q[i] < CW'(MAX_OUTSTANDING))
                   & ~spl_tx_rd_almostfull & spl_reset_n;
      end
   end

   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
      .req    (elig),
      .ptr    (ptr_q),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .any    (gnt_any)
   );

   assign req_ready = gnt;

   // Response acceptance: a response retires a credit if the owner has one in flight,
   // counting a grant to the same requester in this very cycle.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         hit[i] = spl_rx_rd_valid & (rx_id == MDATA_ID_W'(i))
                  & ((cnt_q[i] != '0) | gnt[i]);
      end
      drop = spl_rx_rd_valid & ~(|hit);
   end

   // Next-state for pointer, issue register, credit counters, response register and err.
   always_comb begin
      ptr_d      = ptr_q;
      tx_valid_d = 1'b0;
      tx_addr_d  = tx_addr_q;
      tx_mdata_d = tx_mdata_q;
      if (gnt_any) begin
         ptr_d          = (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
         tx_valid_d     = 1'b1;
         tx_addr_d      = req_addr[gnt_id*ADDR_W +: ADDR_W];
         tx_mdata_d.rsvd = '0;
         tx_mdata_d.id   = MDATA_ID_W'(gnt_id);
         tx_mdata_d.tag  = req_tag[gnt_id*8 +: 8];
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         cnt_d[i] = cnt_q[i];
         if (gnt[i] && !hit[i])
            cnt_d[i] = cnt_q[i] + 1'b1;
         else if (hit[i] && !gnt[i])
            cnt_d[i] = cnt_q[i] - 1'b1;
      end
      rsp_valid_d = hit;
      rsp_tag_d   = rsp_tag_q;
      rsp_data_d  = rsp_data_q;
      if (|hit) begin
         rsp_tag_d  = rx_tag;
         rsp_data_d = spl_rx_data;
      end
      err_d = err_q | drop;
   end

   // State registers; everything returns to its reset value on spl_reset_n low.
   always_ff @(posedge CLK_400M or negedge spl_reset_n) begin
      if (!spl_reset_n) begin
         ptr_q       <= '0;
         tx_valid_q  <= 1'b0;
         tx_addr_q   <= '0;
         tx_mdata_q  <= '0;
         rsp_valid_q <= '0;
         rsp_tag_q   <= '0;
         rsp_data_q  <= '0;
         err_q       <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      end else begin
         ptr_q       <= ptr_d;
         tx_valid_q  <= tx_valid_d;
         tx_addr_q   <= tx_addr_d;
         tx_mdata_q  <= tx_mdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tag_q   <= rsp_tag_d;
         rsp_data_q  <= rsp_data_d;
         err_q       <= err_d;
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Idle when no requester has a read in flight.
   always_comb begin
      idle = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (cnt_q[i] != '0) idle = 1'b0;
      end
   end

   assign afu_tx_rd_valid = tx_valid_q;
   assign afu_tx_rd_addr  = tx_addr_q;
   assign afu_tx_rd_mdata = tx_mdata_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_tag         = rsp_tag_q;
   assign rsp_data        = rsp_data_q;
   assign err             = err_q;

endmodule

// File: doc/smem_rd_arbiter.md
# smem_rd_arbiter

Shares the single CCI-P read-request channel (c0 Tx) among NUM_REQ SMEM pipeline requesters. It round-robin arbitrates their requests and stamps each with a requester ID in mdata. It tracks per-requester outstanding reads against a credit limit, and routes read responses (c0 Rx) back to the owning requester. It sits inside afu_top, between the SMEM processing elements and the ordered (SORT_READ_RESPONSES) MPF read path.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- ADDR_W, 42, CCI-P cache-line address width
- MAX_OUTSTANDING, 32, per-requester in-flight read limit (1..255)
- CLK_400M  in  1  AFU clock; all logic on rising edge
- spl_reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester read request valid
- req_addr  in  NUM_REQ*ADDR_W  per-requester line address, requester i at [i*ADDR_W +: ADDR_W]
- req_tag  in  NUM_REQ*8  per-requester user tag, requester i at [i*8 +: 8]
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid & ready
- spl_tx_rd_almostfull  in  1  c0 Tx almost full
- afu_tx_rd_valid  out  1  read request valid
- afu_tx_rd_addr  out  ADDR_W  read address
- afu_tx_rd_mdata  out  16  {4'b0, id[3:0], tag[7:0]}
- spl_rx_rd_valid  in  1  read response valid
- spl_rx_rd_mdata  in  16  returned mdata
- spl_rx_data  in  512  response data
- rsp_valid  out  NUM_REQ  one-hot response strobe
- rsp_tag  out  8  returned user tag
- rsp_data  out  512  returned line
- idle  out  1  all outstanding counters zero
- err  out  1  sticky protocol error

## Operation
- Eligible(i) = req_valid[i] & (cnt[i] < MAX_OUTSTANDING) & !spl_tx_rd_almostfull.
- Round-robin: search starts at ptr. The first eligible requester gets req_ready=1, combinationally in the same cycle. ptr <= grant+1 (mod NUM_REQ) on grant; ptr holds otherwise.
- At most one grant per cycle. No grant while almostfull is high; a request already registered still issues.
- Issue register: on grant, afu_tx_rd_valid<=1, afu_tx_rd_addr<=req_addr[g], afu_tx_rd_mdata<={4'b0, g, req_tag[g]}. Otherwise valid<=0 and addr/mdata hold.
- cnt[i], width $clog2(MAX_OUTSTANDING+1):
  - +1 on grant to i.
  - -1 on response with id==i.
  - Both in the same cycle: unchanged.
- Response routing: id = spl_rx_rd_mdata[11:8]. On spl_rx_rd_valid:
  - rsp_valid[id]<=1, rsp_tag<=mdata[7:0], rsp_data<=spl_rx_data.
  - Exception, dropped: id >= NUM_REQ, or cnt[id]==0 with no same-cycle grant to id. A dropped response asserts no rsp_valid, sets err, and leaves counters unchanged.
- err clears only on reset. idle = (all cnt==0), combinational from registers.
- Reset mid-operation clears everything. Responses to pre-reset reads find cnt==0, are dropped, and set err. Software reissues after reset.

## Timing
- Reset values:
  - req_ready=0, afu_tx_rd_valid=0, afu_tx_rd_addr=0, afu_tx_rd_mdata=0.
  - rsp_valid=0, rsp_tag=0, rsp_data=0.
  - err=0, idle=1, ptr=0, all cnt=0.
- Request latency: grant cycle N → afu_tx_rd_valid cycle N+1.
- Response latency: spl_rx_rd_valid cycle N → rsp_valid cycle N+1.
- Throughput: 1 request/cycle and 1 response/cycle, concurrently.
- Credit check uses the current-cycle cnt. A requester at MAX-1 granted in cycle N is ineligible in N+1 unless a response to it retires in N.
- Responses arrive in request order per MPF; no reorder buffering.

## Structure
- Package smem_rd_arb_pkg holds:
  - MDATA_ID_LSB=8, MDATA_ID_W=4, MDATA_TAG_W=8
  - typedef t_rd_mdata struct packed {logic [3:0] rsvd; logic [3:0] id; logic [7:0] tag;}
- Sub-module rr_arbiter (params N; inputs req, ptr; outputs one-hot gnt, encoded gnt_id, any). Purely combinational, with a double-width mask-and-priority implementation.
- The top level holds the issue register, counters, response router and err/idle logic.

## Test plan
- All 4 requesters valid continuously, no almostfull → grants 0,1,2,3,0,… one per cycle; afu_tx_rd_mdata[11:8] follows the same sequence one cycle later.
- Requester 2 alone issues 32 reads with no responses → 32 grants, then req_ready[2]=0. One response with mdata=16'h02xx → exactly one more grant.
- almostfull raised in cycle 5 → no req_ready in cycles 5..k while high. The grant from cycle 4 still appears as afu_tx_rd_valid in cycle 5; issue resumes the cycle almostfull falls.
- Response mdata=16'h01A5 with cnt[1]=3 and data=512'hDEAD… → next cycle rsp_valid=4'b0010, rsp_tag=8'hA5, rsp_data matches, cnt[1]=2. A simultaneous grant to 1 leaves cnt[1]=3.
- Response mdata=16'h0700 with NUM_REQ=4, and response id 0 with cnt[0]=0 → no rsp_valid, err=1 and sticky, counters unchanged.
- spl_reset_n pulsed low asynchronously with 10 reads outstanding → all outputs at reset values immediately, idle=1. The late response sets err; a new request is granted normally.
